pipelined_ripple_adder: RTL and testbench
=========================================

# pipelined_ripple_adder

- Parametrised, pipelined ripple-carry add/subtract unit.
- Splits a WIDTH-bit operation into WIDTH/CHUNK ripple stages, one register stage per chunk, so throughput is one operation per clock.
- Adds subtract mode, signed overflow and a valid/ready handshake on both sides.
- Datapath building block for accumulators and address arithmetic; replaces fixed-width combinational ripple adders where timing closes poorly.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK (derived, not overridable).

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (subtract).
- sub  input  1  0: a+b+cin; 1: a−b−cin.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB. In subtract mode: 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Effective operands:
  - b_eff = sub ? ~b : b.
  - c0 = cin ^ sub.
  - Full result: {cout,sum} = a + b_eff + c0 over WIDTH+1 bits.
  - ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff, using the carry registered by stage k−1 (c0 for stage 0).
  - Registers the CHUNK-bit partial sum and the carry.
  - Higher operand chunks travel in skew registers.
  - Lower sum chunks already computed travel in deskew registers.
- The last stage produces cout. ovf is computed from the MSB-chunk operand bits and the final sum MSB; the operand sign bits are carried through the pipeline.
- Each stage holds a valid bit.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv && !rst.
  - A beat transfers on a rising edge with in_valid && in_ready.
  - When adv = 0, all stage registers and valid bits hold. Bubbles are not compressed.
- No reordering or dropping: results emerge in acceptance order, one per transfer.
- No state machine beyond the per-stage valid bits. The skew/deskew registers form the STAGES-deep pipeline.

## Timing
- Latency: a beat accepted at edge n gives out_valid=1 with its result from edge n+STAGES, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput: 1 beat/cycle while out_ready=1.
- Output stability: sum/cout/ovf/out_valid hold constant while out_valid && !out_ready.
- Reset (rst=1 at an edge):
  - All valid bits clear. sum=0, cout=0, ovf=0, out_valid=0 from the next cycle.
  - in_ready=0 while rst is high.
- Reset mid-operation: in-flight beats are discarded and never appear on the output. After rst deasserts, in_ready=1 in the first cycle.
- Simultaneous output pop and input push in the same cycle: both occur and the pipeline shifts by one.
- CHUNK=WIDTH: single stage, latency 1.
- CHUNK=1: WIDTH stages.

## Structure
- Package adder_pkg holds:
  - the stage-count function stages(WIDTH, CHUNK);
  - the mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
- Sub-module chunk_ripple_add:
  - Combinational CHUNK-bit ripple of full adders.
  - Ports: a, b, ci, s, co.
  - Instantiated once per stage by a generate loop.

## Test plan
- WIDTH=16, CHUNK=4: a=16'hFFFF, b=16'h0001, cin=0, sub=0 → 4 cycles later sum=16'h0000, cout=1, ovf=0.
- Subtract: a=16'h0005, b=16'h0007, cin=0, sub=1 → sum=16'hFFFE, cout=0, ovf=0. With cin=1: sum=16'hFFFD.
- Overflow: a=16'h7FFF, b=16'h0001, add → sum=16'h8000, ovf=1, cout=0. Also a=16'h8000, b=16'h0001, sub=1 → sum=16'h7FFF, ovf=1, cout=1.
- Backpressure: stream 8 back-to-back beats and hold out_ready=0 for 3 cycles once out_valid rises. Required: in_ready=0 in those cycles, outputs stable, all 8 results emitted in order with none lost or duplicated.
- Reset mid-flight: 3 beats accepted, then rst=1 for one edge. Required: out_valid=0 and sum=0 next cycle, none of the 3 results ever emitted, and the next accepted beat has latency exactly STAGES.
- Exhaustive WIDTH=4, CHUNK=1, both modes: all 512 {a,b,cin} combinations with randomised in_valid/out_ready. Every result must match the reference model {cout,sum} = a + (sub?~b:b) + (cin^sub), plus ovf.

Source files
------------

// File: rtl/pipelined_ripple_adder_pkg.sv
// adder_pkg: shared constants and stage-count helper for the pipelined ripple adder
package adder_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int stages(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/pipelined_ripple_adder_chunk.sv
// chunk_ripple_add: combinational W-bit ripple of full adders
module chunk_ripple_add #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   logic [W:0] c;

   // full-adder chain, carry rippling from bit 0 upwards
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign co = c[W];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: add/subtract split into CHUNK-bit ripple stages with valid/ready flow control
module pipelined_ripple_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = stages(WIDTH, CHUNK);

   if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
      $error("pipelined_ripple_adder: WIDTH must be a multiple of CHUNK");
   end

   // row 0 captures the operands; row k+1 holds the result of adding chunk k
   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic [STAGES:0]  v_q;
   logic [STAGES:0]  c_q;
   logic [STAGES-1:0] as_q;
   logic [STAGES-1:0] bs_q;
   logic [STAGES-1:0] co_w;
   logic [WIDTH-1:0] a_q   [0:STAGES-1];
   logic [WIDTH-1:0] b_q   [0:STAGES-1];
   logic [WIDTH-1:0] sum_q [1:STAGES];
   logic [WIDTH-1:0] sum_d [0:STAGES-1];
   logic [CHUNK-1:0] s_w   [0:STAGES-1];
   logic             ovf_q;
   logic             ovf_d;

   assign adv      = !v_q[STAGES] || out_ready;
   assign in_ready = adv && !rst;
   assign b_eff    = (sub == MODE_ADD) ? b : ~b;

   // operands are shifted right each row so the active chunk is always the low CHUNK bits;
   // finished sum chunks enter at the top and shift down into place
   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      chunk_ripple_add #(.W(CHUNK)) u_add (
         .a  (a_q[g][CHUNK-1:0]),
         .b  (b_q[g][CHUNK-1:0]),
         .ci (c_q[g]),
         .s  (s_w[g]),
         .co (co_w[g])
      );
      if (g == 0) begin : g_first
         assign sum_d[g] = WIDTH'(s_w[g]) << (WIDTH - CHUNK);
      end else begin : g_rest
         assign sum_d[g] = (sum_q[g] >> CHUNK) | (WIDTH'(s_w[g]) << (WIDTH - CHUNK));
      end
   end

   assign ovf_d = (as_q[STAGES-1] == bs_q[STAGES-1]) && (sum_d[STAGES-1][WIDTH-1] != as_q[STAGES-1]);

   // whole pipeline advances together; a stalled output freezes every row
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= '0;
         c_q   <= '0;
         as_q  <= '0;
         bs_q  <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            sum_q[k+1] <= '0;
         end
      end else if (adv) begin
         v_q    <= {v_q[STAGES-1:0], in_valid};
         c_q    <= {co_w, cin ^ sub};
         as_q   <= STAGES'({as_q, a[WIDTH-1]});
         bs_q   <= STAGES'({bs_q, b_eff[WIDTH-1]});
         ovf_q  <= ovf_d;
         a_q[0] <= a;
         b_q[0] <= b_eff;
         for (int k = 1; k < STAGES; k++) begin
            a_q[k] <= a_q[k-1] >> CHUNK;
            b_q[k] <= b_q[k-1] >> CHUNK;
         end
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k+1] <= sum_d[k];
         end
      end
   end

   assign out_valid = v_q[STAGES];
   assign sum       = sum_q[STAGES];
   assign cout      = c_q[STAGES];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder: directed and exhaustive checks of the pipelined adder against an arithmetic model
module tb_pipelined_ripple_adder;

   logic clk, rst;
   logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [15:0] a, b, sum;
   logic x_in_valid, x_in_ready, x_cin, x_sub, x_out_valid, x_out_ready, x_cout, x_ovf;
   logic [3:0] x_a, x_b, x_sum;

   int checks = 0;
   int errors = 0;

   logic [17:0] q16[$];
   logic [17:0] xq[$];
   int pop16 = 0;
   int xpop = 0;
   logic stall16 = 0, xstall = 0;
   logic [18:0] prev16, xprev;

   pipelined_ripple_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   pipelined_ripple_adder #(.WIDTH(4), .CHUNK(1)) dut_x (
      .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
      .a(x_a), .b(x_b), .cin(x_cin), .sub(x_sub),
      .out_valid(x_out_valid), .out_ready(x_out_ready), .sum(x_sum), .cout(x_cout), .ovf(x_ovf)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   // {ovf, cout, sum} from signed/unsigned integer arithmetic on w-bit operands
   function automatic logic [17:0] model(input int w, input int av, input int bv, input int ci, input int sb);
      int m, r, sa, sbv, sr;
      logic co, ov;
      m   = 1 << w;
      r   = sb != 0 ? av - bv - ci : av + bv + ci;
      co  = sb != 0 ? (r >= 0) : (r >= m);
      sa  = av >= m / 2 ? av - m : av;
      sbv = bv >= m / 2 ? bv - m : bv;
      sr  = sb != 0 ? sa - sbv - ci : sa + sbv + ci;
      ov  = (sr >= m / 2) || (sr < -(m / 2));
      return {ov, co, 16'(r & (m - 1))};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         q16.delete();
         stall16 = 0;
      end else begin
         chk("in_ready16", in_ready, !out_valid || out_ready);
         if (stall16) chk("stable16", {out_valid, ovf, cout, sum}, prev16);
         if (out_valid) begin
            if (q16.size() == 0) chk("spurious16", out_valid, 0);
            else begin
               chk("result16", {ovf, cout, sum}, q16[0]);
               if (out_ready) begin
                  void'(q16.pop_front());
                  pop16++;
               end
            end
         end
         if (in_valid && in_ready) q16.push_back(model(16, a, b, cin, sub));
         stall16 = out_valid && !out_ready;
         prev16  = {out_valid, ovf, cout, sum};
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         xq.delete();
         xstall = 0;
      end else begin
         if (xstall) chk("stable4", {x_out_valid, x_ovf, x_cout, 12'h000, x_sum}, xprev);
         if (x_out_valid) begin
            if (xq.size() == 0) chk("spurious4", x_out_valid, 0);
            else begin
               chk("result4", {x_ovf, x_cout, 12'h000, x_sum}, xq[0]);
               if (x_out_ready) begin
                  void'(xq.pop_front());
                  xpop++;
               end
            end
         end
         if (x_in_valid && x_in_ready) xq.push_back(model(4, x_a, x_b, x_cin, x_sub));
         xstall = x_out_valid && !x_out_ready;
         xprev  = {x_out_valid, x_ovf, x_cout, 12'h000, x_sum};
      end
   end

   task automatic run1(input string n, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic sb, input logic [17:0] exp);
      int lat;
      a = av; b = bv; cin = ci; sub = sb; in_valid = 1; out_ready = 1;
      #1 chk({n, "_accept"}, in_ready, 1);
      @(posedge clk);
      #1 in_valid = 0;
      lat = 0;
      while (!out_valid && lat < 12) begin
         @(posedge clk);
         #1 lat++;
      end
      chk({n, "_latency"}, lat, 4);
      chk({n, "_result"}, {ovf, cout, sum}, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, cyc, stalls, base;
      bit started;
      rst = 1; in_valid = 0; out_ready = 1; a = 0; b = 0; cin = 0; sub = 0;
      x_in_valid = 0; x_out_ready = 1; x_a = 0; x_b = 0; x_cin = 0; x_sub = 0;
      chk("pin_add_wrap", model(16, 'hFFFF, 1, 0, 0), {1'b0, 1'b1, 16'h0000});
      chk("pin_sub_neg", model(16, 5, 7, 0, 1), {1'b0, 1'b0, 16'hFFFE});
      chk("pin_ovf_sub", model(16, 'h8000, 1, 0, 1), {1'b1, 1'b1, 16'h7FFF});
      chk("pin_4b_add", model(4, 'hF, 'hF, 1, 0), {1'b0, 1'b1, 16'h000F});
      chk("pin_4b_ovf", model(4, 8, 0, 1, 1), {1'b1, 1'b1, 16'h0007});
      repeat (2) @(posedge clk);
      #1 chk("rst_in_ready", in_ready, 0);
      chk("rst_out", {out_valid, ovf, cout, sum}, 0);
      chk("rst_out4", {x_out_valid, x_ovf, x_cout, x_sum}, 0);
      rst = 0;

      run1("add_wrap", 16'hFFFF, 16'h0001, 0, 0, {1'b0, 1'b1, 16'h0000});
      run1("sub_neg", 16'h0005, 16'h0007, 0, 1, {1'b0, 1'b0, 16'hFFFE});
      run1("sub_neg_bin", 16'h0005, 16'h0007, 1, 1, {1'b0, 1'b0, 16'hFFFD});
      run1("ovf_add", 16'h7FFF, 16'h0001, 0, 0, {1'b1, 1'b0, 16'h8000});
      run1("ovf_sub", 16'h8000, 16'h0001, 0, 1, {1'b1, 1'b1, 16'h7FFF});

      // backpressure: 8 back-to-back beats, out_ready low for 3 cycles once out_valid rises
      base = pop16; idx = 0; cyc = 0; stalls = 0; started = 0;
      while ((idx < 8 || q16.size() != 0) && cyc < 80) begin
         if (!started && out_valid) begin
            started = 1;
            stalls = 3;
         end
         out_ready = (stalls == 0);
         in_valid = idx < 8;
         a = 16'(idx * 'h1357 + 'h0F0F);
         b = 16'(idx * 'h2468 + 3);
         cin = idx[0];
         sub = idx[1];
         #1;
         if (stalls != 0) chk("bp_in_ready", in_ready, 0);
         if (in_valid && in_ready) idx++;
         @(posedge clk);
         #1;
         if (stalls > 0) stalls--;
         cyc++;
      end
      in_valid = 0; out_ready = 1;
      chk("bp_stalled", started, 1);
      chk("bp_sent", idx, 8);
      chk("bp_count", pop16 - base, 8);

      // reset with three beats in flight
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; a = 16'(i * 'h1111); b = 16'h0101; cin = 0; sub = 0;
         #1 chk("rf_accept", in_ready, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 0; rst = 1;
      #1 chk("rf_in_ready_rst", in_ready, 0);
      @(posedge clk);
      #1 rst = 0;
      #1 chk("rf_out_cleared", {out_valid, ovf, cout, sum}, 0);
      chk("rf_in_ready_after", in_ready, 1);
      base = pop16;
      run1("rf_next", 16'h1234, 16'h4321, 1, 0, {1'b0, 1'b0, 16'h5556});
      repeat (8) @(posedge clk);
      #1 chk("rf_count", pop16 - base, 1);

      // exhaustive 4-bit, both modes, random handshakes
      idx = 0; cyc = 0;
      while (idx < 1024 && cyc < 20000) begin
         x_out_ready = $urandom_range(0, 3) != 0;
         x_in_valid = $urandom_range(0, 3) != 0;
         x_sub = idx[9];
         {x_a, x_b, x_cin} = idx[8:0];
         #1;
         if (x_in_valid && x_in_ready) idx++;
         @(posedge clk);
         #1 cyc++;
      end
      x_in_valid = 0; x_out_ready = 1;
      while (xq.size() != 0 && cyc < 20000) begin
         @(posedge clk);
         #1 cyc++;
      end
      @(posedge clk);
      #1 chk("exh_sent", idx, 1024);
      chk("exh_count", xpop, 1024);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
